// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM states and flag layout for alu_pipe.
// Used by alu_pipe and alu_mul_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int FLG_Z   = 0;
    localparam int FLG_N   = 1;
    localparam int FLG_C   = 2;
    localparam int FLG_V   = 3;
    localparam int FLG_ERR = 4;

    function automatic logic [4:0] pack_flags(
        input logic err,
        input logic v,
        input logic c,
        input logic n,
        input logic z
    );
        logic [4:0] f;
        f          = '0;
        f[FLG_ERR] = err;
        f[FLG_V]   = v;
        f[FLG_C]   = c;
        f[FLG_N]   = n;
        f[FLG_Z]   = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one bit per cycle.
// done is high after WIDTH iterations; product holds the low WIDTH bits.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             last;

    assign last    = (cnt_q == CW'(WIDTH));
    assign done    = busy_q && last;
    assign product = acc_q;

    // Load operands on start, then add/shift once per cycle until done.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (last) begin
                busy_d = 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    // Multiplier state registers; reset drops any partial product.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and {ERR,V,C,N,Z} flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 0100.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             valid_q, valid_d;
    logic             accept;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   sh_amt;
    logic             sh_big;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;
    logic [4:0]       alu_flg;

`ifdef ALU_MUL_EN
    state_e           state_q, state_d;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

    assign in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready);
`else
    assign in_ready = !valid_q || out_ready;
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Single-cycle datapath: result and flags for the presented opcode.
    always_comb begin
        sum_w   = {1'b0, a} + {1'b0, b};
        diff_w  = {1'b0, a} - {1'b0, b};
        sh_amt  = b[SHW-1:0];
        sh_big  = |b[WIDTH-1:SHW];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: alu_res = sh_big ? '0 : (a << sh_amt);
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SRL: alu_res = sh_big ? '0 : (a >> sh_amt);
            OP_SRA: begin
                if (sh_big) begin
                    alu_res = {WIDTH{a[WIDTH-1]}};
                end else begin
                    alu_res = WIDTH'($signed(a) >>> sh_amt);
                end
            end
`ifdef ALU_MUL_EN
            OP_MUL: alu_res = '0;
`endif
            default: alu_err = 1'b1;
        endcase
        alu_flg = pack_flags(alu_err, alu_v, alu_c,
                             alu_res[WIDTH-1], alu_res == '0);
    end

    // Output slot and FSM: retire on out_ready, load on accept or mul done.
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
`ifdef ALU_MUL_EN
        state_d   = state_q;
        mul_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flg;
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_prod;
                    flags_d  = pack_flags(1'b0, 1'b0, 1'b0,
                                          mul_prod[WIDTH-1],
                                          mul_prod == '0);
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        if (accept) begin
            result_d = alu_res;
            flags_d  = alu_flg;
            valid_d  = 1'b1;
        end
`endif
    end

    // Registered output slot and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
            state_q  <= ST_IDLE;
`endif
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
`ifdef ALU_MUL_EN
            state_q  <= state_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe (WIDTH=16)
// against an arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int checks = 0;
    int errors = 0;

    alu_pipe #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {ERR,V,C,N,Z, result[15:0]} from plain integer arithmetic.
    function automatic logic [20:0] model(input int op, input int x,
                                          input int y);
        longint s;
        int     r;
        int     sx;
        int     sy;
        bit     c = 1'b0;
        bit     v = 1'b0;
        bit     e = 1'b0;
        logic [31:0] rv;
        sx = (x >= 32768) ? x - 65536 : x;
        sy = (y >= 32768) ? y - 65536 : y;
        r  = 0;
        case (op)
            0: begin
                s = longint'(x) + longint'(y);
                r = int'(s % 65536);
                c = (s >= 65536);
                s = longint'(sx) + longint'(sy);
                v = (s > 32767) || (s < -32768);
            end
            1: begin
                r = (x - y + 65536) % 65536;
                c = (x < y);
                s = longint'(sx) - longint'(sy);
                v = (s > 32767) || (s < -32768);
            end
            2: r = (y >= 16) ? 0 : (x << y) % 65536;
            3: r = x & y;
            5: r = x | y;
            6: r = x ^ y;
            7: r = (y >= 16) ? 0 : (x >> y);
            8: r = (sx >>> ((y >= 16) ? 15 : y)) & 65535;
`ifdef ALU_MUL_EN
            4: r = int'((longint'(x) * longint'(y)) % 65536);
`endif
            default: begin
                e = 1'b1;
                r = 0;
            end
        endcase
        rv = r;
        return {e, v, c, (r >= 32768), (r == 0), rv[15:0]};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, output logic [W-1:0] r,
                         output logic [4:0] f);
        logic [20:0] m;
        m = model(int'(op), int'(aa), int'(bb));
        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = op;
        a         = aa;
        b         = bb;
        out_ready = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef ALU_MUL_EN
        if (op == 4'b0100) begin
            int n = 0;
            bit busy_rdy = 1'b0;
            while (!out_valid && n < 40) begin
                if (in_ready) busy_rdy = 1'b1;
                @(posedge clk);
                #1;
                n++;
            end
            check("mul_latency", 32'(n), 32'(W + 1));
            check("mul_stall", 32'(busy_rdy), 32'd0);
        end
`endif
        check("issue_valid", 32'(out_valid), 32'd1);
        check("issue_result", 32'(result), 32'(m[15:0]));
        check("issue_flags", 32'(flags), 32'(m[20:16]));
        r = result;
        f = flags;
    endtask

    initial begin
        logic [W-1:0] r;
        logic [4:0]   f;
        logic [20:0]  m;
        logic [3:0]   op;
        bit           stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);

        issue(4'h0, 16'h7FFF, 16'h0001, r, f);
        check("add_ovf_r", 32'(r), 32'h8000);
        check("add_ovf_f", 32'(f), 32'b01010);
        issue(4'h1, 16'h0003, 16'h0005, r, f);
        check("sub_brw_r", 32'(r), 32'hFFFE);
        check("sub_brw_f", 32'(f), 32'b00110);
        issue(4'h1, 16'h0005, 16'h0005, r, f);
        check("sub_zero_r", 32'(r), 32'h0000);
        check("sub_zero_f", 32'(f), 32'b00001);
        issue(4'h2, 16'h0001, 16'd4, r, f);
        check("sll4", 32'(r), 32'h0010);
        issue(4'h2, 16'h0001, 16'd20, r, f);
        check("sll20_r", 32'(r), 32'h0000);
        check("sll20_f", 32'(f), 32'b00001);
        issue(4'h8, 16'h8000, 16'd15, r, f);
        check("sra15", 32'(r), 32'hFFFF);
        issue(4'h8, 16'h8000, 16'd40, r, f);
        check("sra40", 32'(r), 32'hFFFF);
        issue(4'h7, 16'h8000, 16'd15, r, f);
        check("srl15", 32'(r), 32'h0001);
        issue(4'h4, 16'h0012, 16'h0034, r, f);
`ifdef ALU_MUL_EN
        check("mul_r", 32'(r), 32'h03A8);
        check("mul_f", 32'(f), 32'b00000);
`else
        check("mul_off_r", 32'(r), 32'h0000);
        check("mul_off_f", 32'(f), 32'b10001);
`endif

        // Backpressure: result held, pending input waits, then accepted.
        @(negedge clk);
        wait_ready();
        in_valid  = 1'b1;
        opcode    = 4'h0;
        a         = 16'h0001;
        b         = 16'h0002;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_first", 32'(result), 32'h0003);
        @(negedge clk);
        out_ready = 1'b0;
        a         = 16'h0010;
        b         = 16'h0020;
        #1;
        check("bp_stall", 32'(in_ready), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_hold_r", 32'(result), 32'h0003);
            check("bp_hold_v", 32'(out_valid), 32'd1);
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_r", 32'(result), 32'h0030);
        check("bp_next_v", 32'(out_valid), 32'd1);

        // Reset in the middle of a multiply.
        @(negedge clk);
        wait_ready();
        in_valid  = 1'b1;
        opcode    = 4'h4;
        a         = 16'h0012;
        b         = 16'h0034;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) stale = 1'b1;
        end
        check("mrst_stale", 32'(stale), 32'd0);

        issue(4'hF, 16'h1234, 16'h5678, r, f);
        check("illegal_r", 32'(r), 32'h0000);
        check("illegal_f", 32'(f), 32'b10001);

        // Random back-to-back single-cycle ops at full throughput.
        @(negedge clk);
        wait_ready();
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
            if (op == 4'h4) op = 4'h6;
`endif
            a = 16'($urandom);
            if ($urandom_range(0, 2) == 0) b = 16'($urandom_range(0, 20));
            else b = 16'($urandom);
            opcode    = op;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            m = model(int'(op), int'(a), int'(b));
            check("rnd_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            check("rnd_valid", 32'(out_valid), 32'd1);
            check("rnd_result", 32'(result), 32'(m[15:0]));
            check("rnd_flags", 32'(flags), 32'(m[20:16]));
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Random multiplies (illegal-op path when the multiplier is absent).
        for (int i = 0; i < 6; i++) begin
            issue(4'h4, 16'($urandom), 16'($urandom), r, f);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
